pulse_period_monitor: RTL and testbench
=======================================

PULSE_PERIOD_MONITOR -- requirements
Module: pulse_period_monitor

Interface
REQ-001 Parameter BITS, default 13, is the width of the period counter and of Period_O.
REQ-002 Parameter COUNT, default 4999; the expected period is COUNT+1 clocks, matching the periodic tick generator's terminal count.
REQ-003 Parameter TOL, default 2, is the accepted deviation of a period from COUNT+1, in clocks.
REQ-004 Parameter LOCK_N, default 4, is the number of consecutive in-window periods required to lock.
REQ-005 Clock_I  input  1  sole clock, rising edge.
REQ-006 Reset_n_I  input  1  asynchronous, active-low reset.
REQ-007 Pulse_I  input  1  periodic sync pulse; a rising edge marks one event, and any high duration is allowed.
REQ-008 Period_O  output  BITS  clocks between the last two detected edges.
REQ-009 Period_Valid_O  output  1  one-cycle strobe when Period_O updates.
REQ-010 Locked_O  output  1  high while in state LOCKED.
REQ-011 Err_Early_O  output  1  one-cycle strobe for a period shorter than COUNT+1-TOL.
REQ-012 Err_Late_O  output  1  one-cycle strobe when no edge arrives by COUNT+1+TOL clocks.
REQ-013 Err_Count_O  output  8  saturating count of early plus late errors.

Function
REQ-014 The edge strobe SHALL be high for one cycle when the sampled pulse level is 1 and its previous value is 0.
REQ-015 The period counter SHALL load 1 on an edge cycle, otherwise increment, and saturate at 2^BITS-1 with no wrap.
REQ-016 On an edge, the block SHALL register Period_O equal to the counter value and pulse Period_Valid_O on the next clock, except for the first edge after reset.
REQ-017 The block SHALL implement states IDLE, ACQUIRE and LOCKED; reset enters IDLE.
REQ-018 IDLE SHALL move to ACQUIRE on the first edge, with no Period_Valid_O and no error.
REQ-019 A period P SHALL be good when COUNT+1-TOL <= P <= COUNT+1+TOL; a good period increments good_cnt.
REQ-020 In ACQUIRE, when good_cnt reaches LOCK_N the block SHALL enter LOCKED.
REQ-021 An early period SHALL pulse Err_Early_O, clear good_cnt, and send LOCKED or ACQUIRE to ACQUIRE.
REQ-022 When the counter first equals COUNT+2+TOL without an edge, the block SHALL pulse Err_Late_O once per gap, clear good_cnt, and send LOCKED to ACQUIRE.
REQ-023 An edge in the same cycle as the late threshold SHALL produce exactly one Err_Late_O and a valid, non-good period.
REQ-024 An edge after a late gap SHALL report the period (possibly saturated), count it as not good, and raise no additional error.
REQ-025 Err_Count_O SHALL increment once per error strobe and hold at 255.
REQ-026 COUNT+1+TOL+1 SHALL be less than 2^BITS; a violation is reported as an elaboration-time error.

Reset
REQ-027 While Reset_n_I is low, the block SHALL hold: all outputs 0, counter 0, good_cnt 0, state IDLE, edge-detect and synchronizer registers 0.
REQ-028 A reset asserted mid-period SHALL discard the partial measurement; the first edge after release is treated as first-edge.

Configuration
REQ-029 With macro PULSE_MON_SYNC_EN defined, Pulse_I SHALL pass through a two-flop synchronizer before edge detection, giving 3 clocks from Pulse_I rising to Period_Valid_O.
REQ-030 Without PULSE_MON_SYNC_EN, Pulse_I SHALL be treated as synchronous to Clock_I and registered once, giving 1 clock from Pulse_I rising to Period_Valid_O.

Structure
REQ-031 The state encoding (IDLE=0, ACQUIRE=1, LOCKED=2) and the error-counter width SHALL reside in package pulse_mon_pkg.
REQ-032 The synchronizer plus edge detector SHALL be sub-module pulse_edge_detect; the counter, FSM and outputs SHALL reside in the top level.

Verification (COUNT=9, TOL=1, LOCK_N=3)
REQ-033 Five edges spaced 10 clocks -> Period_O=10 four times; Locked_O rises after the fourth edge; no errors.
REQ-034 Locked, then an edge 7 clocks after the previous one -> Err_Early_O once, Locked_O=0, Err_Count_O=1, Period_O=7.
REQ-035 Locked, then pulses stop -> Err_Late_O exactly once at counter=12; Locked_O=0; a later edge raises no further error.
REQ-036 Periods of 9, 11 and 10 -> all good; lock after three periods.
REQ-037 Pulse_I held high for 4 clocks per event -> one edge per event; periods are measured rising-to-rising.
REQ-038 Reset asserted for 2 clocks mid-period while locked -> all outputs 0 immediately; the next edge produces no Period_Valid_O.

Source files
------------

// File: rtl/pulse_mon_pkg.sv
// Shared types for the pulse period monitor: FSM state encoding and error counter width.
package pulse_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector for the sync pulse; macro PULSE_MON_SYNC_EN adds a two-flop synchronizer.
module pulse_edge_detect
  import pulse_mon_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pulse_i,
  output logic edge_o
);

  logic level_s;
  logic prev_q;

`ifdef PULSE_MON_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pulse_i;
      sync2_q <= sync1_q;
    end
  end

  assign level_s = sync2_q;
`else
  // Input is synchronous to the clock: the previous-value flop is the only register.
  assign level_s = pulse_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= level_s;
  end

  assign edge_o = level_s & ~prev_q;

endmodule

// File: rtl/pulse_period_monitor.sv
// Measures the spacing of sync-pulse rising edges, locks after LOCK_N in-window periods,
// flags early/late periods. Optional macro: PULSE_MON_SYNC_EN (input synchronizer).
module pulse_period_monitor
  import pulse_mon_pkg::*;
#(
  parameter int unsigned BITS   = 13,
  parameter int unsigned COUNT  = 4999,
  parameter int unsigned TOL    = 2,
  parameter int unsigned LOCK_N = 4
) (
  input  logic                 Clock_I,
  input  logic                 Reset_n_I,
  input  logic                 Pulse_I,
  output logic [BITS-1:0]      Period_O,
  output logic                 Period_Valid_O,
  output logic                 Locked_O,
  output logic                 Err_Early_O,
  output logic                 Err_Late_O,
  output logic [ERR_CNT_W-1:0] Err_Count_O
);

  localparam int unsigned GW = $clog2(LOCK_N + 1);
  localparam logic [BITS-1:0] GOOD_LO = BITS'(COUNT + 1 - TOL);
  localparam logic [BITS-1:0] GOOD_HI = BITS'(COUNT + 1 + TOL);
  localparam logic [BITS-1:0] LATE_AT = BITS'(COUNT + 2 + TOL);
  localparam logic [BITS-1:0] CNT_MAX = '1;

  if (COUNT + TOL + 2 >= (2 ** BITS)) begin : g_bits_check
    $error("pulse_period_monitor: COUNT+1+TOL+1 must be less than 2**BITS");
  end

  logic edge_s;

  pulse_edge_detect u_edge (
    .clk_i   (Clock_I),
    .rst_ni  (Reset_n_I),
    .pulse_i (Pulse_I),
    .edge_o  (edge_s)
  );

  state_e                 state_q, state_d;
  logic [BITS-1:0]        cnt_q, cnt_d;
  logic [GW-1:0]          good_q, good_d;
  logic [GW-1:0]          good_inc;
  logic                   late_seen_q, late_seen_d;
  logic                   late_hit;
  logic [BITS-1:0]        period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   early_q, early_d;
  logic                   late_q, late_d;
  logic [ERR_CNT_W-1:0]   errcnt_q, errcnt_d;

  always_ff @(posedge Clock_I or negedge Reset_n_I) begin
    if (!Reset_n_I) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      good_q      <= '0;
      late_seen_q <= 1'b0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      early_q     <= 1'b0;
      late_q      <= 1'b0;
      errcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      good_q      <= good_d;
      late_seen_q <= late_seen_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      early_q     <= early_d;
      late_q      <= late_d;
      errcnt_q    <= errcnt_d;
    end
  end

  assign good_inc = good_q + GW'(1);
  // late_seen_q keeps a saturated counter parked on LATE_AT from re-firing within one gap.
  assign late_hit = (state_q != ST_IDLE) && !late_seen_q && (cnt_q == LATE_AT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + BITS'(1);
    good_d      = good_q;
    late_seen_d = late_seen_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    early_d     = 1'b0;
    late_d      = 1'b0;
    errcnt_d    = errcnt_q;

    if (late_hit) begin
      late_d      = 1'b1;
      late_seen_d = 1'b1;
      good_d      = '0;
      if (state_q == ST_LOCKED) state_d = ST_ACQUIRE;
    end

    if (edge_s) begin
      cnt_d       = BITS'(1);
      late_seen_d = 1'b0;
      if (state_q == ST_IDLE) begin
        state_d = ST_ACQUIRE;
        good_d  = '0;
      end else begin
        period_d = cnt_q;
        valid_d  = 1'b1;
        if (cnt_q < GOOD_LO) begin
          early_d = 1'b1;
          good_d  = '0;
          state_d = ST_ACQUIRE;
        end else if (cnt_q <= GOOD_HI) begin
          if (good_q != GW'(LOCK_N)) good_d = good_inc;
          if (state_q == ST_ACQUIRE && good_inc == GW'(LOCK_N)) state_d = ST_LOCKED;
        end else begin
          good_d = '0;
        end
      end
    end

    if ((early_d || late_d) && errcnt_q != '1) errcnt_d = errcnt_q + ERR_CNT_W'(1);
  end

  assign Period_O       = period_q;
  assign Period_Valid_O = valid_q;
  assign Locked_O       = (state_q == ST_LOCKED);
  assign Err_Early_O    = early_q;
  assign Err_Late_O     = late_q;
  assign Err_Count_O    = errcnt_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Directed bench for pulse_period_monitor with COUNT=9, TOL=1, LOCK_N=3 (good window 9..11, late at 12).
module tb_pulse_period_monitor;

  localparam int unsigned BITS = 8;

  logic            clk;
  logic            rst_n;
  logic            pulse;
  logic [BITS-1:0] period;
  logic            valid;
  logic            locked;
  logic            err_early;
  logic            err_late;
  logic [7:0]      err_cnt;

  pulse_period_monitor #(
    .BITS   (BITS),
    .COUNT  (9),
    .TOL    (1),
    .LOCK_N (3)
  ) dut (
    .Clock_I        (clk),
    .Reset_n_I      (rst_n),
    .Pulse_I        (pulse),
    .Period_O       (period),
    .Period_Valid_O (valid),
    .Locked_O       (locked),
    .Err_Early_O    (err_early),
    .Err_Late_O     (err_late),
    .Err_Count_O    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_valid, n_early, n_late, last_period, sum_period;
  int last_valid_cyc = 0;
  int late_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      last_period = int'(period);
      sum_period += int'(period);
      last_valid_cyc = cyc;
    end
    if (err_early) n_early++;
    if (err_late) begin
      n_late++;
      late_gap = cyc - last_valid_cyc;
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One event: pulse high for hi cycles, next event starts per cycles later.
  task automatic send(input int per, input int hi);
    pulse = 1'b1;
    tick(hi);
    pulse = 1'b0;
    tick(per - hi);
  endtask

  task automatic clear_stats();
    n_valid = 0; n_early = 0; n_late = 0; last_period = -1; sum_period = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    pulse = 1'b0;
    clear_stats();
    tick(3);
    check_val("rst_period", int'(period), 0);
    check_val("rst_valid",  int'(valid), 0);
    check_val("rst_locked", int'(locked), 0);
    check_val("rst_early",  int'(err_early), 0);
    check_val("rst_late",   int'(err_late), 0);
    check_val("rst_errcnt", int'(err_cnt), 0);
    rst_n = 1'b1;
    tick(3);

    // Nominal period, lock after the fourth edge
    clear_stats();
    for (int i = 0; i < 3; i++) send(10, 1);
    check_val("lock_before_4th", int'(locked), 0);
    send(10, 1);
    check_val("lock_after_4th", int'(locked), 1);
    send(10, 1);
    check_val("nom_nvalid", n_valid, 4);
    check_val("nom_period", last_period, 10);
    check_val("nom_sum", sum_period, 40);
    check_val("nom_errors", n_early + n_late, 0);

    // Early period while locked
    clear_stats();
    send(7, 1);
    send(9, 1);
    check_val("early_n", n_early, 1);
    check_val("early_period", last_period, 7);
    check_val("early_locked", int'(locked), 0);
    check_val("early_errcnt", int'(err_cnt), 1);

    // Window edges 9 and 11 count as good
    clear_stats();
    send(11, 1);
    send(10, 1);
    check_val("win_lock_pre", int'(locked), 0);
    send(10, 1);
    check_val("win_lock", int'(locked), 1);
    check_val("win_sum", sum_period, 30);
    check_val("win_errors", n_early + n_late, 0);

    // Pulses stop: one late error at counter 12
    clear_stats();
    tick(5);
    check_val("late_n", n_late, 1);
    check_val("late_gap", late_gap, 12);
    check_val("late_locked", int'(locked), 0);
    check_val("late_errcnt", int'(err_cnt), 2);
    tick(20);
    check_val("late_once", n_late, 1);
    send(10, 1);
    check_val("late_edge_period", last_period, 35);
    check_val("late_edge_noerr", n_late + n_early, 1);
    check_val("late_edge_errcnt", int'(err_cnt), 2);

    // Edge coincident with the late threshold
    clear_stats();
    tick(2);
    send(10, 1);
    check_val("thr_late", n_late, 1);
    check_val("thr_nvalid", n_valid, 1);
    check_val("thr_period", last_period, 12);
    check_val("thr_errcnt", int'(err_cnt), 3);
    send(10, 1);
    send(10, 1);
    check_val("thr_not_good", int'(locked), 0);
    send(10, 1);
    check_val("thr_relock", int'(locked), 1);

    // Wide pulses: one edge per event
    clear_stats();
    for (int i = 0; i < 3; i++) send(10, 4);
    check_val("wide_nvalid", n_valid, 3);
    check_val("wide_sum", sum_period, 30);
    check_val("wide_early", n_early, 0);
    check_val("wide_locked", int'(locked), 1);

    // Reset mid-period while locked
    send(5, 1);
    check_val("mid_locked_pre", int'(locked), 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_locked", int'(locked), 0);
    check_val("mid_rst_period", int'(period), 0);
    check_val("mid_rst_errcnt", int'(err_cnt), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    clear_stats();
    send(10, 1);
    check_val("post_rst_first", n_valid, 0);
    send(10, 1);
    check_val("post_rst_nvalid", n_valid, 1);
    check_val("post_rst_period", last_period, 10);

    // Error counter saturation
    clear_stats();
    for (int i = 0; i < 260; i++) send(2, 1);
    check_val("sat_early_n", n_early, 259);
    check_val("sat_errcnt", int'(err_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
